uart_wb_bridge: RTL

UART-driven Wishbone initiator for host debug access. Receives framed read/write commands on a serial line, issues one 32-bit Wishbone classic cycle per command, and returns a status byte plus read data over the serial transmit line. It sits at the SoC top level as a second bus master, next to the CPU, and addresses the same slave fabric as the UART peripheral and the other wishbone responders.

---
 rtl/uart_wb_bridge_pkg.sv | 18 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 68 ++++++
 rtl/uart_tx.sv | 81 ++++++++
 rtl/uart_wb_bridge.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/uart_wb_bridge_pkg.sv
// Shared constants and state encoding for the UART-to-Wishbone debug bridge.
package uart_wb_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RESP_OK   = 8'h4B;
  localparam logic [7:0] RESP_ERR  = 8'h45;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP,
    SEND_DATA
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a configurable reset level.
module sync_2ff #(
  parameter logic DEFAULT = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      meta <= DEFAULT;
      o_q  <= DEFAULT;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver; pulses o_valid for one clock at mid stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  rx_state_t       st;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      st      <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (!i_rx) st <= RX_START;
        end
        // Re-check the start bit half a bit later to reject glitches.
        RX_START: begin
          if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            st      <= i_rx ? RX_IDLE : RX_BITS;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_BITS: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            o_data  <= {i_rx, o_data[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) st <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            o_valid <= i_rx;
            st      <= RX_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; accepts a byte on i_valid while o_ready is high.
module uart_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_BITS, TX_STOP} tx_state_t;

  tx_state_t     st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign o_ready = (st == TX_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      st      <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      o_tx    <= 1'b1;
    end else begin
      case (st)
        TX_IDLE: begin
          o_tx <= 1'b1;
          cnt  <= '0;
          if (i_valid) begin
            shreg <= i_data;
            o_tx  <= 1'b0;
            st    <= TX_START;
          end
        end
        TX_START: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            o_tx    <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            st      <= TX_BITS;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        TX_BITS: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_tx <= 1'b1;
              st   <= TX_STOP;
            end else begin
              o_tx    <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
            st  <= TX_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_wb_bridge.sv
// UART-driven Wishbone classic initiator: parses read/write frames,
// runs one 32-bit bus cycle per frame and returns status plus read data.
module uart_wb_bridge
  import uart_wb_bridge_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int UART_BAUD  = 115200,
  parameter int WB_TIMEOUT = 1024,
  parameter int RX_TIMEOUT = 250000,
  parameter int USE_SYNC   = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic        o_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / UART_BAUD;
  localparam int WBW          = $clog2(WB_TIMEOUT + 1);
  localparam int RXW          = $clog2(RX_TIMEOUT + 1);

  logic           rx_s;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           tx_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;

  state_t         state;
  logic           cyc;
  logic [1:0]     byte_cnt;
  logic [WBW-1:0] wb_cnt;
  logic [RXW-1:0] idle_cnt;
  logic [31:0]    rdata;
  logic           resp_err;

  generate
    if (USE_SYNC != 0) begin : g_sync
      sync_2ff #(.DEFAULT(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
      );
    end else begin : g_nosync
      assign rx_s = i_rx;
    end
  endgenerate

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_rx    (rx_s),
    .o_data  (rx_data),
    .o_valid (rx_valid)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (tx_data),
    .i_valid (tx_valid),
    .o_ready (tx_ready),
    .o_tx    (o_tx)
  );

  assign o_wb_cyc = cyc;
  assign o_wb_stb = cyc;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state     <= IDLE;
      cyc       <= 1'b0;
      o_wb_sel  <= '0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      o_busy    <= 1'b0;
      byte_cnt  <= '0;
      wb_cnt    <= '0;
      idle_cnt  <= '0;
      rdata     <= '0;
      resp_err  <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      tx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
            o_wb_we  <= (rx_data == CMD_WRITE);
            o_busy   <= 1'b1;
            byte_cnt <= '0;
            idle_cnt <= '0;
            state    <= ADDR;
          end
        end
        ADDR, DATA: begin
          if (rx_valid) begin
            idle_cnt <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == ADDR) o_wb_addr <= {o_wb_addr[23:0], rx_data};
            else               o_wb_data <= {o_wb_data[23:0], rx_data};
            if (byte_cnt == 2'd3) begin
              if (state == ADDR && o_wb_we) begin
                state <= DATA;
              end else begin
                state    <= BUS;
                cyc      <= 1'b1;
                o_wb_sel <= 4'hF;
                wb_cnt   <= '0;
              end
            end
          end else if (idle_cnt == RXW'(RX_TIMEOUT - 1)) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + RXW'(1);
          end
        end
        // err wins over ack; a timeout is reported the same way as err.
        BUS: begin
          if (i_wb_err || i_wb_ack || wb_cnt == WBW'(WB_TIMEOUT - 1)) begin
            cyc      <= 1'b0;
            o_wb_sel <= '0;
            resp_err <= i_wb_err || !i_wb_ack;
            rdata    <= i_wb_data;
            state    <= RESP;
          end else begin
            wb_cnt <= wb_cnt + WBW'(1);
          end
        end
        RESP: begin
          if (tx_valid) begin
            if (!resp_err && !o_wb_we) begin
              byte_cnt <= '0;
              state    <= SEND_DATA;
            end else begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end
          end else if (tx_ready) begin
            tx_valid <= 1'b1;
            tx_data  <= resp_err ? RESP_ERR : RESP_OK;
          end
        end
        SEND_DATA: begin
          if (tx_valid) begin
            rdata    <= {rdata[23:0], 8'h00};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end
          end else if (tx_ready) begin
            tx_valid <= 1'b1;
            tx_data  <= rdata[31:24];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
